// File: rtl/logic_gate_pkg.sv
// Shared types and the gate evaluation function for the logic gate bank.
// gate_eval takes a zero-extended operand plus the live operand width.
package logic_gate_pkg;

    localparam int LED_NOT = 0;
    localparam int LED_AND = 1;
    localparam int LED_OR  = 2;
    localparam int LED_XOR = 3;
    localparam int MAX_SW  = 32;

    typedef logic [3:0] led_t;

    function automatic led_t gate_eval(
        input logic [MAX_SW-1:0] op,
        input int                width
    );
        led_t r;
        logic a;
        logic o;
        logic x;
        a = op[0];
        o = op[0];
        x = op[0];
        for (int i = 1; i < MAX_SW; i++) begin
            if (i < width) begin
                a = a & op[i];
                o = o | op[i];
                x = x ^ op[i];
            end
        end
        r          = '0;
        r[LED_NOT] = ~op[0];
        r[LED_AND] = a;
        r[LED_OR]  = o;
        r[LED_XOR] = x;
        return r;
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// One switch bit: 2-flop synchroniser followed by a stability counter.
// A change is accepted after DEBOUNCE_CYCLES consecutive mismatching edges.
module sw_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_sw,
    output logic o_deb
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          r_s1;
    logic          r_s2;
    logic          r_deb;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_deb <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_s1 <= i_sw;
            r_s2 <= r_s1;
            if (r_s2 == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                r_deb <= r_s2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_deb = r_deb;

endmodule

// File: rtl/logic_gate_bank.sv
// NUM_SW-input NOT/AND/OR/XOR gate bank with debounced switches,
// an auto-sweep operand source and a one-cycle LED change strobe.
module logic_gate_bank
    import logic_gate_pkg::*;
#(
    parameter int NUM_SW          = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SWEEP_PERIOD    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_SW-1:0] SW,
    input  logic              SWEEP,
    output led_t              LED,
    output logic [NUM_SW-1:0] OP_VEC,
    output logic              CHANGE_STRB
);

    localparam int PW = (SWEEP_PERIOD > 1) ? $clog2(SWEEP_PERIOD) : 1;

    logic [NUM_SW-1:0] w_deb;
    logic [NUM_SW-1:0] w_op;
    led_t              w_led_next;

    logic              r_swp_s1;
    logic              r_swp_s2;
    logic [PW-1:0]     r_pre;
    logic [NUM_SW-1:0] r_sweep_cnt;
    led_t              r_led;
    logic              r_primed;
    logic              r_chg;
    logic              r_strb;

    for (genvar g = 0; g < NUM_SW; g++) begin : g_deb
        sw_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk  (clk),
            .reset(reset),
            .i_sw (SW[g]),
            .o_deb(w_deb[g])
        );
    end

    assign w_op       = r_swp_s2 ? r_sweep_cnt : w_deb;
    assign w_led_next = gate_eval(MAX_SW'(w_op), NUM_SW);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_swp_s1    <= 1'b0;
            r_swp_s2    <= 1'b0;
            r_pre       <= '0;
            r_sweep_cnt <= '0;
        end else begin
            r_swp_s1 <= SWEEP;
            r_swp_s2 <= r_swp_s1;
            if (!r_swp_s2) begin
                r_pre       <= '0;
                r_sweep_cnt <= '0;
            end else if (r_pre == PW'(SWEEP_PERIOD - 1)) begin
                r_pre       <= '0;
                r_sweep_cnt <= r_sweep_cnt + 1'b1;
            end else begin
                r_pre <= r_pre + 1'b1;
            end
        end
    end

    // r_chg marks the edge LED changed; the strobe lands one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_led    <= '0;
            r_primed <= 1'b0;
            r_chg    <= 1'b0;
            r_strb   <= 1'b0;
        end else begin
            r_led    <= w_led_next;
            r_primed <= 1'b1;
            r_chg    <= r_primed && (w_led_next != r_led);
            r_strb   <= r_chg;
        end
    end

    assign LED         = r_led;
    assign OP_VEC      = w_op;
    assign CHANGE_STRB = r_strb;

endmodule

// File: tb/tb_logic_gate_bank.sv
// Directed bench for logic_gate_bank: 2-bit instance plus a 3-bit instance.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_logic_gate_bank;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] sw = 2'b00;
    logic       sweep = 1'b0;
    logic [3:0] led;
    logic [1:0] op;
    logic       strb;

    logic [2:0] sw3 = 3'b000;
    logic       sweep3 = 1'b0;
    logic [3:0] led3;
    logic [2:0] op3;
    logic       strb3;

    int pass_cnt = 0;
    int total = 0;

    logic [3:0] led2 [4];

    always #5 clk = ~clk;

    logic_gate_bank #(
        .NUM_SW(2), .DEBOUNCE_CYCLES(4), .SWEEP_PERIOD(8)
    ) dut (
        .clk(clk), .reset(reset), .SW(sw), .SWEEP(sweep),
        .LED(led), .OP_VEC(op), .CHANGE_STRB(strb)
    );

    logic_gate_bank #(
        .NUM_SW(3), .DEBOUNCE_CYCLES(4), .SWEEP_PERIOD(8)
    ) dut3 (
        .clk(clk), .reset(reset), .SW(sw3), .SWEEP(sweep3),
        .LED(led3), .OP_VEC(op3), .CHANGE_STRB(strb3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        led2[0] = 4'b0001;
        led2[1] = 4'b1100;
        led2[2] = 4'b1101;
        led2[3] = 4'b0110;

        // reset held 3 cycles
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_led", led, 4'b0000);
            check("rst_strb", strb, 1'b0);
        end
        reset = 1'b0;
        tick();
        check("rel_led", led, 4'b0001);
        check("rel_op", op, 2'b00);
        check("rel_strb", strb, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rel_nostrb", strb, 1'b0);
        end

        // SW 00 -> 11
        sw = 2'b11;
        for (int k = 0; k <= 8; k++) begin
            tick();
            check("sw11_led", led, (k >= 6) ? 4'b0110 : 4'b0001);
            check("sw11_op", op, (k >= 5) ? 2'b11 : 2'b00);
            check("sw11_strb", strb, (k == 7) ? 1'b1 : 1'b0);
        end

        // back to 00, then 3-cycle glitch
        sw = 2'b00;
        for (int i = 0; i < 10; i++) tick();
        check("ret00_led", led, 4'b0001);
        check("ret00_op", op, 2'b00);
        sw = 2'b11;
        tick();
        tick();
        tick();
        sw = 2'b00;
        for (int i = 0; i < 12; i++) begin
            check("glitch_led", led, 4'b0001);
            check("glitch_op", op, 2'b00);
            check("glitch_strb", strb, 1'b0);
            tick();
        end

        // sweep mode
        sweep = 1'b1;
        for (int k = 0; k <= 40; k++) begin
            tick();
            check("sweep_op", op,
                  (k < 9) ? 0 : ((k - 9) / 8 + 1) % 4);
            check("sweep_led", led,
                  (k < 10) ? led2[0] : led2[((k - 10) / 8 + 1) % 4]);
            check("sweep_strb", strb,
                  (k >= 11 && (k - 11) % 8 == 0) ? 1'b1 : 1'b0);
        end
        sweep = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("manual_op", op, 2'b00);
        check("manual_led", led, 4'b0001);

        // 3-bit instance
        sw3 = 3'b111;
        for (int i = 0; i < 6; i++) tick();
        check("w3_111_early", led3, 4'b0001);
        tick();
        check("w3_111", led3, 4'b1110);
        sw3 = 3'b110;
        for (int i = 0; i < 8; i++) tick();
        check("w3_110", led3, 4'b0101);
        check("w3_110_op", op3, 3'b110);
        sw3 = 3'b000;
        for (int i = 0; i < 8; i++) tick();
        check("w3_000", led3, 4'b0001);

        // reset during a partial debounce count
        sw = 2'b01;
        tick();
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        tick();
        check("mid_rst_led", led, 4'b0000);
        check("mid_rst_op", op, 2'b00);
        check("mid_rst_strb", strb, 1'b0);
        reset = 1'b0;
        for (int k = 0; k <= 8; k++) begin
            tick();
            check("post_led", led, (k >= 6) ? 4'b1100 : 4'b0001);
            check("post_strb", strb, (k == 7) ? 1'b1 : 1'b0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
